// File: rtl/mac_result_capture_pkg.sv
// Shared types and constants for the MAC result capture block: FSM states,
// binary16 field positions, flag bit indices and the stored entry layout.
package mac_result_capture_pkg;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned FLAG_W      = 4;
  localparam int unsigned DLY_W       = 3;
  localparam int unsigned OCC_W       = 2;
  localparam int unsigned DOT_LEN_DEF = 8;
  localparam int unsigned ACC_LAT_DEF = 2;

  localparam int unsigned EXP_MSB = 14;
  localparam int unsigned EXP_LSB = 10;
  localparam int unsigned MAN_MSB = 9;

  localparam int unsigned FLAG_NAN  = 3;
  localparam int unsigned FLAG_INF  = 2;
  localparam int unsigned FLAG_SUB  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Sign-agnostic binary16 class decode.
  function automatic logic [FLAG_W-1:0] classify(input logic [DATA_W-1:0] v);
    logic              exp_ones;
    logic              exp_zero;
    logic              man_nz;
    logic [FLAG_W-1:0] f;
    exp_ones     = &v[EXP_MSB:EXP_LSB];
    exp_zero     = ~|v[EXP_MSB:EXP_LSB];
    man_nz       = |v[MAN_MSB:0];
    f            = '0;
    f[FLAG_NAN]  = exp_ones & man_nz;
    f[FLAG_INF]  = exp_ones & ~man_nz;
    f[FLAG_SUB]  = exp_zero & man_nz;
    f[FLAG_ZERO] = exp_zero & ~man_nz;
    return f;
  endfunction

endpackage

// File: rtl/mac_result_capture_if.sv
// Bundle of the MAC wrapper observation inputs and the result valid/ready bus.
interface mac_result_capture_if;
  import mac_result_capture_pkg::*;

  logic [CNT_W-1:0]  counter;
  logic [DATA_W-1:0] mac_result;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [FLAG_W-1:0] res_flags;
  logic [OCC_W-1:0]  res_count;
  logic              overrun;
  logic              busy;

  modport master (
    input  counter, mac_result, res_ready,
    output res_valid, res_data, res_flags, res_count, overrun, busy
  );

  modport slave (
    output counter, mac_result, res_ready,
    input  res_valid, res_data, res_flags, res_count, overrun, busy
  );

endinterface

// File: rtl/mac_result_capture_result_fifo2.sv
// 2-deep synchronous FIFO built as a head/tail register pair; a push and pop
// in the same cycle are both accepted even when full.
module result_fifo2 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [1:0]   cnt;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop & (cnt != 2'd0);
  assign push_ok = push & ((cnt != 2'd2) | pop_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= din;
          else             slot1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = slot0;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/mac_result_capture.sv
// Captures the final MAC accumulator value once per dot-product run and queues
// it in a 2-entry valid/ready buffer. RESULT_FLAGS_EN adds per-entry class flags.
module mac_result_capture
  import mac_result_capture_pkg::*;
#(
  parameter int unsigned DOT_LEN = DOT_LEN_DEF,
  parameter int unsigned ACC_LAT = ACC_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  mac_result_capture_if.master bus
);

`ifdef RESULT_FLAGS_EN
  localparam int unsigned ENTRY_W = $bits(entry_t);
`else
  localparam int unsigned ENTRY_W = DATA_W;
`endif

  state_t             state;
  state_t             state_next;
  logic [DLY_W-1:0]   delay;
  logic [DLY_W-1:0]   delay_next;
  logic               capture_c;
  logic               pop_c;
  logic               busy_q;
  logic               overrun_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      delay <= '0;
    end else begin
      state <= state_next;
      delay <= delay_next;
    end
  end

  // Run tracking: arm on counter==0, time the drain after DOT_LEN, capture once.
  always_comb begin
    state_next = state;
    delay_next = delay;
    capture_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.counter == CNT_W'(0)) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (bus.counter == CNT_W'(DOT_LEN)) begin
          if (ACC_LAT == 0) begin
            capture_c  = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_WAIT;
            delay_next = DLY_W'(ACC_LAT);
          end
        end
      end
      ST_WAIT: begin
        if (bus.counter == CNT_W'(0)) begin
          state_next = ST_ARMED;
          delay_next = '0;
        end else if (delay == DLY_W'(1)) begin
          capture_c  = 1'b1;
          state_next = ST_DONE;
          delay_next = '0;
        end else begin
          delay_next = delay - DLY_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.counter == CNT_W'(0)) state_next = ST_ARMED;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign pop_c = ~fifo_empty & bus.res_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      busy_q <= (state_next == ST_WAIT);
      if (capture_c && fifo_full && !pop_c) overrun_q <= 1'b1;
    end
  end

`ifdef RESULT_FLAGS_EN
  entry_t ent_in;
  entry_t ent_out;
  assign ent_in        = '{flags: classify(bus.mac_result), data: bus.mac_result};
  assign fifo_din      = ent_in;
  assign ent_out       = fifo_dout;
  assign bus.res_data  = ent_out.data;
  assign bus.res_flags = ent_out.flags;
`else
  assign fifo_din      = bus.mac_result;
  assign bus.res_data  = fifo_dout;
  assign bus.res_flags = '0;
`endif

  result_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture_c),
    .pop   (pop_c),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (bus.res_count)
  );

  assign bus.res_valid = ~fifo_empty;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mac_result_capture.sv
// Self-checking bench for mac_result_capture: directed vectors, multi-cycle
// corner sequences and randomized runs against a queue-based reference model.
module tb_mac_result_capture;

  localparam int DOT_LEN = 8;
  localparam int ACC_LAT = 2;

  logic clk;
  logic reset;

  mac_result_capture_if bus();

  mac_result_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  logic [15:0] q_data[$];
  bit          m_armed;
  int          m_left;
  bit          m_over;

  int          valid_seen;
  logic [15:0] last_data;
  logic [3:0]  last_flags;

  typedef struct {
    logic [15:0] mac;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [3:0] ref_flags(input logic [15:0] v);
    int e;
    int mn;
    logic [3:0] f;
    e  = (int'(v) / 1024) % 32;
    mn = int'(v) % 1024;
    f  = 4'b0000;
    if (e == 31)     f = (mn != 0) ? 4'b1000 : 4'b0100;
    else if (e == 0) f = (mn != 0) ? 4'b0010 : 4'b0001;
`ifdef RESULT_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  function automatic logic [3:0] fmask();
`ifdef RESULT_FLAGS_EN
    return 4'hF;
`else
    return 4'h0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q_data.delete();
    m_armed = 1'b0;
    m_left  = -1;
    m_over  = 1'b0;
  endtask

  // One clock edge of the reference behaviour, from the values sampled at that edge.
  task automatic model_edge(input logic [3:0] c, input logic [15:0] m, input logic r);
    bit cap;
    cap = 1'b0;
    if (r && q_data.size() > 0) void'(q_data.pop_front());
    if (c == 4'd0) begin
      m_armed = 1'b1;
      m_left  = -1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        cap     = 1'b1;
        m_armed = 1'b0;
        m_left  = -1;
      end
    end else if (m_armed && int'(c) == DOT_LEN) begin
      if (ACC_LAT == 0) begin
        cap     = 1'b1;
        m_armed = 1'b0;
      end else begin
        m_left = ACC_LAT;
      end
    end
    if (cap) begin
      if (q_data.size() < 2) q_data.push_back(m);
      else                   m_over = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check("valid", 32'(bus.res_valid), 32'(q_data.size() > 0));
    check("count", 32'(bus.res_count), 32'(q_data.size()));
    check("overrun", 32'(bus.overrun), 32'(m_over));
    check("busy", 32'(bus.busy), 32'(m_left > 0));
    if (q_data.size() > 0) begin
      check("data", 32'(bus.res_data), 32'(q_data[0]));
      check("flags", 32'(bus.res_flags), 32'(ref_flags(q_data[0])));
    end
    if (bus.res_valid && bus.res_ready) begin
      valid_seen++;
      last_data  = bus.res_data;
      last_flags = bus.res_flags;
    end
  endtask

  task automatic step(input logic [3:0] c, input logic [15:0] m, input logic r);
    bus.counter    = c;
    bus.mac_result = m;
    bus.res_ready  = r;
    @(posedge clk);
    model_edge(c, m, r);
    #1;
    check_outputs();
  endtask

  function automatic logic rdy(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return (mode != 0);
  endfunction

  task automatic run(input logic [15:0] m, input int hold, input int rmode);
    for (int i = 0; i < DOT_LEN; i++) step(4'(i), 16'($urandom), rdy(rmode));
    for (int h = 0; h < hold; h++) step(4'(DOT_LEN), m, rdy(rmode));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_data", 32'(bus.res_data), 32'd0);
    check("rst_flags", 32'(bus.res_flags), 32'd0);
    check("rst_count", 32'(bus.res_count), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [15:0] rand_mac();
    logic [15:0] sp[6];
    sp[0] = 16'h7E00; sp[1] = 16'h7C00; sp[2] = 16'h0001;
    sp[3] = 16'h8000; sp[4] = 16'hFC01; sp[5] = 16'h0000;
    if ($urandom_range(0, 2) == 0) return sp[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    n_pass         = 0;
    n_total        = 0;
    valid_seen     = 0;
    last_data      = '0;
    last_flags     = '0;
    reset          = 1'b1;
    bus.counter    = 4'd0;
    bus.mac_result = 16'h0000;
    bus.res_ready  = 1'b0;
    model_reset();
    #2;
    apply_reset();

    vecs[0] = '{16'h4800, 4'b0000};
    vecs[1] = '{16'h7E00, 4'b1000};
    vecs[2] = '{16'h7C00, 4'b0100};
    vecs[3] = '{16'h0001, 4'b0010};
    vecs[4] = '{16'h8000, 4'b0001};
    vecs[5] = '{16'hFC00, 4'b0100};
    vecs[6] = '{16'h83FF, 4'b0010};
    vecs[7] = '{16'h7C01, 4'b1000};

    // Basic latency: valid appears after the third edge seeing counter==8.
    for (int i = 0; i < DOT_LEN; i++) step(4'(i), 16'h1234, 1'b1);
    step(4'd8, 16'h4800, 1'b1);
    check("lat_e1", 32'(bus.res_valid), 32'd0);
    step(4'd8, 16'h4800, 1'b1);
    check("lat_e2", 32'(bus.res_valid), 32'd0);
    step(4'd8, 16'h4800, 1'b1);
    check("lat_e3", 32'(bus.res_valid), 32'd1);
    check("lat_data", 32'(bus.res_data), 32'h4800);
    step(4'd8, 16'h4800, 1'b1);
    check("lat_e4", 32'(bus.res_valid), 32'd0);

    for (int v = 0; v < 8; v++) begin
      valid_seen = 0;
      run(vecs[v].mac, 4, 1);
      check("vec_seen", 32'(valid_seen), 32'd1);
      check("vec_data", 32'(last_data), 32'(vecs[v].mac));
      check("vec_flags", 32'(last_flags), 32'(vecs[v].flags & fmask()));
    end

    // Overrun with consumer stalled, then ordered drain.
    run(16'h3C00, 4, 0);
    run(16'h4000, 4, 0);
    run(16'h4200, 4, 0);
    check("ovr_count", 32'(bus.res_count), 32'd2);
    check("ovr_flag", 32'(bus.overrun), 32'd1);
    check("ovr_head0", 32'(bus.res_data), 32'h3C00);
    step(4'd8, 16'h0, 1'b1);
    check("ovr_head1", 32'(bus.res_data), 32'h4000);
    step(4'd8, 16'h0, 1'b1);
    check("ovr_empty", 32'(bus.res_valid), 32'd0);

    valid_seen = 0;
    run(16'h4400, 50, 1);
    check("hold_once", 32'(valid_seen), 32'd1);

    // Aborts: drop at 5, and drop during the drain wait.
    valid_seen = 0;
    for (int i = 0; i <= 5; i++) step(4'(i), 16'h5555, 1'b1);
    repeat (3) step(4'd0, 16'h5555, 1'b1);
    check("abort5_none", 32'(valid_seen), 32'd0);
    for (int i = 1; i < DOT_LEN; i++) step(4'(i), 16'h6666, 1'b1);
    step(4'd8, 16'h6666, 1'b1);
    check("abort8_busy", 32'(bus.busy), 32'd1);
    step(4'd0, 16'h6666, 1'b1);
    check("abort8_idle", 32'(bus.busy), 32'd0);
    repeat (4) step(4'd0, 16'h6666, 1'b1);
    check("abort8_none", 32'(valid_seen), 32'd0);
    run(16'h5000, 4, 1);
    check("abort_rerun", 32'(valid_seen), 32'd1);
    check("abort_data", 32'(last_data), 32'h5000);

    // Reset with two entries buffered and a capture pending.
    run(16'h1111, 4, 0);
    run(16'h2222, 4, 0);
    for (int i = 0; i < DOT_LEN; i++) step(4'(i), 16'h7777, 1'b0);
    step(4'd8, 16'h7777, 1'b0);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    check("pre_rst_count", 32'(bus.res_count), 32'd2);
    apply_reset();
    valid_seen = 0;
    repeat (10) step(4'd8, 16'h7777, 1'b1);
    check("post_rst_none", 32'(valid_seen), 32'd0);
    run(16'h3333, 4, 1);
    check("post_rst_run", 32'(valid_seen), 32'd1);
    check("post_rst_data", 32'(last_data), 32'h3333);

    // Randomized runs, aborts, noise and resets.
    for (int it = 0; it < 200; it++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind <= 4) begin
        run(rand_mac(), int'($urandom_range(1, 6)), 2);
      end else if (kind <= 6) begin
        int k;
        k = int'($urandom_range(1, 8));
        for (int i = 0; i < k; i++) step(4'(i), rand_mac(), rdy(2));
        step(4'd0, rand_mac(), rdy(2));
      end else if (kind <= 8) begin
        repeat ($urandom_range(1, 5)) step(4'($urandom_range(0, 15)), rand_mac(), rdy(2));
      end else begin
        apply_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
